// File: rtl/sram_dma_copy_if.sv
// SRAM pin bundle between the DMA engine (master) and the 8K x 8 single-port SRAM (slave).
interface sram_dma_copy_if #(
  parameter int A_WIDTH = 13,
  parameter int D_WIDTH = 8
);
  logic [A_WIDTH-1:0] Mem_Addr;
  logic               Mem_RW;
  logic               Mem_En;
  logic [D_WIDTH-1:0] Mem_Wdata;
  logic [D_WIDTH-1:0] Mem_Rdata;

  modport master (output Mem_Addr, Mem_RW, Mem_En, Mem_Wdata, input Mem_Rdata);
  modport slave  (input Mem_Addr, Mem_RW, Mem_En, Mem_Wdata, output Mem_Rdata);
endinterface

// File: rtl/sram_dma_copy.sv
// Block copy / fill engine driving a single-port SRAM; reports a 16-bit additive checksum of written bytes.
module sram_dma_copy #(
  parameter int A_WIDTH = 13,
  parameter int D_WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic               Mode,
  input  logic [A_WIDTH-1:0] Src_Addr,
  input  logic [A_WIDTH-1:0] Dst_Addr,
  input  logic [A_WIDTH:0]   Length,
  input  logic [D_WIDTH-1:0] Fill_Data,
  output logic               Busy,
  output logic               Done,
  output logic [15:0]        Checksum,
  sram_dma_copy_if.master    mem
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [A_WIDTH:0] IDX_ONE = {{A_WIDTH{1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [A_WIDTH-1:0] src_q, src_d;
  logic [A_WIDTH-1:0] dst_q, dst_d;
  logic [A_WIDTH:0]   len_q, len_d;
  logic [D_WIDTH-1:0] fill_q, fill_d;
  logic [A_WIDTH:0]   idx_q, idx_d;
  logic [15:0]        csum_q, csum_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [A_WIDTH:0]   idx_inc;
  logic [D_WIDTH-1:0] wr_data;

  assign idx_inc = idx_q + IDX_ONE;
  // Read data arrives one cycle after the READ address, i.e. during WRITE.
  assign wr_data = mode_q ? fill_q : mem.Mem_Rdata;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          mode_d  = Mode;
          src_d   = Src_Addr;
          dst_d   = Dst_Addr;
          len_d   = Length;
          fill_d  = Fill_Data;
          idx_d   = '0;
          csum_d  = '0;
          if (Length == '0) state_d = DONE;
          else if (Mode)    state_d = WRITE;
          else              state_d = READ;
        end
      end
      READ: state_d = WRITE;
      WRITE: begin
        csum_d = csum_q + 16'(wr_data);
        idx_d  = idx_inc;
        if (idx_inc == len_q) state_d = DONE;
        else if (mode_q)      state_d = WRITE;
        else                  state_d = READ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Checksum = csum_q;

  // Address arithmetic drops the carry so regions wrap at the top of memory.
  always_comb begin
    mem.Mem_Addr  = '0;
    mem.Mem_RW    = 1'b0;
    mem.Mem_En    = 1'b0;
    mem.Mem_Wdata = '0;
    case (state_q)
      READ: begin
        mem.Mem_En   = 1'b1;
        mem.Mem_Addr = src_q + idx_q[A_WIDTH-1:0];
      end
      WRITE: begin
        mem.Mem_En    = 1'b1;
        mem.Mem_RW    = 1'b1;
        mem.Mem_Addr  = dst_q + idx_q[A_WIDTH-1:0];
        mem.Mem_Wdata = wr_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_dma_copy.sv
// Directed bench for sram_dma_copy with a behavioural 8K x 8 SRAM (registered read data).
module tb_sram_dma_copy;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int MAXC = 64;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Start = 1'b0;
  logic          Mode = 1'b0;
  logic [AW-1:0] Src_Addr = '0;
  logic [AW-1:0] Dst_Addr = '0;
  logic [AW:0]   Length = '0;
  logic [DW-1:0] Fill_Data = '0;
  logic          Busy, Done;
  logic [15:0]   Checksum;

  sram_dma_copy_if #(.A_WIDTH(AW), .D_WIDTH(DW)) mem_if ();

  sram_dma_copy #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Mode(Mode),
    .Src_Addr(Src_Addr), .Dst_Addr(Dst_Addr), .Length(Length), .Fill_Data(Fill_Data),
    .Busy(Busy), .Done(Done), .Checksum(Checksum), .mem(mem_if)
  );

  always #5 Clk = ~Clk;

  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic [DW-1:0] sram_dout = '0;
  assign mem_if.Mem_Rdata = sram_dout;
  always @(posedge Clk) begin
    if (mem_if.Mem_En) begin
      if (mem_if.Mem_RW) sram[mem_if.Mem_Addr] <= mem_if.Mem_Wdata;
      else               sram_dout <= sram[mem_if.Mem_Addr];
    end
  end

  int checks = 0;
  int errors = 0;

  logic          tr_busy [0:MAXC];
  logic          tr_en   [0:MAXC];
  logic          tr_rw   [0:MAXC];
  logic          tr_done [0:MAXC];
  logic [AW-1:0] tr_addr [0:MAXC];
  logic [15:0]   tr_csum [0:MAXC];
  int            done_cyc;

  // Issue a command: Start is high in cycle 0; returns sampled in cycle 1.
  task automatic start_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW:0] n, input logic [DW-1:0] f);
    @(negedge Clk);
    Mode = m; Src_Addr = s; Dst_Addr = d; Length = n; Fill_Data = f; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  // Record per-cycle outputs from cycle 1 up to Done (or max); optional Start pulse / Rst cycle.
  task automatic collect(input int max, input int pulse_cyc, input int rst_cyc);
    done_cyc = -1;
    for (int c = 1; c <= max; c++) begin
      tr_busy[c] = Busy; tr_en[c] = mem_if.Mem_En; tr_rw[c] = mem_if.Mem_RW;
      tr_done[c] = Done; tr_addr[c] = mem_if.Mem_Addr; tr_csum[c] = Checksum;
      Start = (c == pulse_cyc);
      if (c == pulse_cyc) begin Dst_Addr = 13'h0300; Mode = 1'b0; Length = 14'd1; end
      Rst = (c == rst_cyc);
      if (Done && done_cyc < 0) done_cyc = c;
      @(posedge Clk); #1;
      Start = 1'b0; Rst = 1'b0;
      if (done_cyc >= 0) break;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (Busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %0b exp 0", Busy); end
    checks++; if (Done !== 1'b0)   begin errors++; $display("FAIL reset_done got %0b exp 0", Done); end
    checks++; if (Checksum !== 16'h0) begin errors++; $display("FAIL reset_csum got %h exp 0000", Checksum); end
    checks++; if (mem_if.Mem_En !== 1'b0 || mem_if.Mem_RW !== 1'b0 || mem_if.Mem_Addr !== '0 || mem_if.Mem_Wdata !== '0)
      begin errors++; $display("FAIL reset_mem en=%0b rw=%0b addr=%h wd=%h exp all 0",
        mem_if.Mem_En, mem_if.Mem_RW, mem_if.Mem_Addr, mem_if.Mem_Wdata); end
    Rst = 1'b0;
  endtask

  task automatic test_copy();
    logic [DW-1:0] exp_b [4];
    int busy_bad;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) sram[13'h0010 + k] = exp_b[k];
    start_cmd(1'b0, 13'h0010, 13'h0100, 14'd4, 8'h00);
    collect(30, 0, 0);
    checks++; if (done_cyc != 9) begin errors++; $display("FAIL copy_done_cycle got %0d exp 9", done_cyc); end
    busy_bad = 0;
    for (int c = 1; c <= 9; c++) if (tr_busy[c] !== 1'b1) busy_bad++;
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL copy_busy low in %0d of cycles 1-9 exp 0", busy_bad); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (sram[13'h0100 + k] !== exp_b[k])
        begin errors++; $display("FAIL copy_data[%0d] got %h exp %h", k, sram[13'h0100 + k], exp_b[k]); end
    end
    checks++; if (Checksum !== 16'h00AA) begin errors++; $display("FAIL copy_csum got %h exp 00aa", Checksum); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL copy_idle_busy got %0b exp 0", Busy); end
  endtask

  task automatic test_fill();
    int wr_bad;
    start_cmd(1'b1, 13'h0000, 13'h0200, 14'd3, 8'hFF);
    collect(30, 0, 0);
    wr_bad = 0;
    for (int c = 1; c <= 3; c++) if (tr_en[c] !== 1'b1 || tr_rw[c] !== 1'b1 || tr_addr[c] !== 13'h0200 + 13'(c - 1)) wr_bad++;
    checks++; if (wr_bad != 0) begin errors++; $display("FAIL fill_write_cycles bad=%0d exp 0", wr_bad); end
    checks++; if (done_cyc != 4) begin errors++; $display("FAIL fill_done_cycle got %0d exp 4", done_cyc); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (sram[13'h0200 + k] !== 8'hFF)
        begin errors++; $display("FAIL fill_data[%0d] got %h exp ff", k, sram[13'h0200 + k]); end
    end
    checks++; if (Checksum !== 16'h02FD) begin errors++; $display("FAIL fill_csum got %h exp 02fd", Checksum); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [3];
    exp_a = '{13'h1FFE, 13'h1FFF, 13'h0000};
    sram[13'h1FFE] = 8'h01; sram[13'h1FFF] = 8'h02; sram[13'h0000] = 8'h03;
    start_cmd(1'b0, 13'h1FFE, 13'h0800, 14'd3, 8'h00);
    collect(30, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (tr_en[2*k+1] !== 1'b1 || tr_rw[2*k+1] !== 1'b0 || tr_addr[2*k+1] !== exp_a[k])
        begin errors++; $display("FAIL wrap_read_addr[%0d] got %h en=%0b rw=%0b exp %h read",
          k, tr_addr[2*k+1], tr_en[2*k+1], tr_rw[2*k+1], exp_a[k]); end
      checks++; if (sram[13'h0800 + k] !== 8'(k + 1))
        begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", k, sram[13'h0800 + k], 8'(k + 1)); end
    end
    checks++; if (Checksum !== 16'h0006) begin errors++; $display("FAIL wrap_csum got %h exp 0006", Checksum); end
  endtask

  task automatic test_len0();
    int en_seen;
    start_cmd(1'b0, 13'h0010, 13'h0900, 14'd0, 8'h00);
    collect(10, 0, 0);
    checks++; if (done_cyc != 1) begin errors++; $display("FAIL len0_done_cycle got %0d exp 1", done_cyc); end
    en_seen = 0;
    if (done_cyc > 0) for (int c = 1; c <= done_cyc; c++) if (tr_en[c] !== 1'b0) en_seen++;
    checks++; if (en_seen != 0) begin errors++; $display("FAIL len0_mem_en asserted %0d cycles exp 0", en_seen); end
    checks++; if (tr_csum[1] !== 16'h0) begin errors++; $display("FAIL len0_csum got %h exp 0000", tr_csum[1]); end
  endtask

  task automatic test_start_while_busy();
    sram[13'h0300] = 8'h5A;
    for (int k = 0; k < 4; k++) sram[13'h0A00 + k] = 8'h00;
    start_cmd(1'b0, 13'h0010, 13'h0A00, 14'd4, 8'h00);
    collect(30, 3, 0);
    checks++; if (done_cyc != 9) begin errors++; $display("FAIL busy_start_done_cycle got %0d exp 9", done_cyc); end
    checks++; if (sram[13'h0300] !== 8'h5A) begin errors++; $display("FAIL busy_start_untouched got %h exp 5a", sram[13'h0300]); end
    checks++; if (sram[13'h0A03] !== 8'h44) begin errors++; $display("FAIL busy_start_last_word got %h exp 44", sram[13'h0A03]); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL busy_start_requeued busy=%0b exp 0", Busy); end
  endtask

  task automatic test_reset_mid();
    start_cmd(1'b0, 13'h0010, 13'h0400, 14'd4, 8'h00);
    collect(20, 0, 4);
    checks++; if (tr_csum[4] !== 16'h0011) begin errors++; $display("FAIL rst_pre_csum got %h exp 0011", tr_csum[4]); end
    checks++; if (tr_busy[5] !== 1'b0 || tr_done[5] !== 1'b0 || tr_csum[5] !== 16'h0 || tr_en[5] !== 1'b0)
      begin errors++; $display("FAIL rst_mid_state busy=%0b done=%0b csum=%h en=%0b exp 0/0/0000/0",
        tr_busy[5], tr_done[5], tr_csum[5], tr_en[5]); end
    checks++; if (done_cyc != -1) begin errors++; $display("FAIL rst_no_done got done at %0d exp none", done_cyc); end
    start_cmd(1'b1, 13'h0000, 13'h0500, 14'd1, 8'h77);
    collect(10, 0, 0);
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL rst_fill_done_cycle got %0d exp 2", done_cyc); end
    checks++; if (sram[13'h0500] !== 8'h77) begin errors++; $display("FAIL rst_fill_data got %h exp 77", sram[13'h0500]); end
    checks++; if (Checksum !== 16'h0077) begin errors++; $display("FAIL rst_fill_csum got %h exp 0077", Checksum); end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) sram[a] = 8'h00;
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_len0();
    test_start_while_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
